// File: rtl/top_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : top_pkg
// Description : Shared constants, transmit FSM states and the Life rule for
//               the 8x8 Game-of-Life WS2812B display.
// Revision    : 1.0 - initial release
// ============================================================================
package top_pkg;

  // WS2812B bit timing in clk cycles (80 ns each)
  localparam int BIT_CYCLES   = 15;
  localparam int T0H          = 5;
  localparam int T1H          = 10;
  localparam int LATCH_CYCLES = 1000;
  localparam int N_LEDS       = 64;
  localparam int BITS_PER_LED = 24;

  // Glider seed: cells (0,1),(1,2),(2,0),(2,1),(2,2); bit index is r*8+c
  localparam logic [63:0] SEED_BOARD = 64'h0000_0000_0007_0402;

  typedef enum logic {
    LATCH = 1'b0,
    SEND  = 1'b1
  } tx_state_t;

  // Conway rule: birth on exactly 3, survival on 2 or 3
  function automatic logic life_rule(input logic alive, input logic [3:0] n);
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ws2812_tx
// Description : Serialises one 24-bit GRB word, MSB first, as WS2812B pulses.
//               A start coinciding with led_done chains the next LED with no
//               idle cycle. Output is registered so the data line is clean.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_tx
  import top_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] grb,
  output logic        dout,
  output logic        led_done
);

  logic        busy, busy_n;
  logic [3:0]  phase, phase_n;
  logic [4:0]  bit_idx, bit_n;
  logic [23:0] shreg, sh_n;
  logic        last_phase;
  logic [3:0]  high_n;

  assign last_phase = (phase == 4'(BIT_CYCLES - 1));
  assign led_done   = busy && last_phase && (bit_idx == 5'(BITS_PER_LED - 1));
  assign high_n     = sh_n[23] ? 4'(T1H) : 4'(T0H);

  // Next-state: load on start, otherwise advance phase / bit / shift register
  always_comb begin
    busy_n  = busy;
    phase_n = phase;
    bit_n   = bit_idx;
    sh_n    = shreg;
    if (start && (!busy || led_done)) begin
      busy_n  = 1'b1;
      phase_n = 4'd0;
      bit_n   = 5'd0;
      sh_n    = grb;
    end else if (busy) begin
      if (last_phase) begin
        phase_n = 4'd0;
        if (bit_idx == 5'(BITS_PER_LED - 1)) begin
          busy_n = 1'b0;
        end else begin
          bit_n = bit_idx + 5'd1;
          sh_n  = {shreg[22:0], 1'b0};
        end
      end else begin
        phase_n = phase + 4'd1;
      end
    end
  end

  // State registers; dout is decoded from the next state so it lines up with phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      phase   <= 4'd0;
      bit_idx <= 5'd0;
      shreg   <= 24'd0;
      dout    <= 1'b0;
    end else begin
      busy    <= busy_n;
      phase   <= phase_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      dout    <= busy_n && (phase_n < high_n);
    end
  end

endmodule
`default_nettype wire

// File: rtl/top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : top
// Description : 8x8 toroidal Game of Life shown on a WS2812B matrix. Frames
//               refresh continuously; generation steps are committed only in
//               the latch gap so every frame shows a single generation.
// Revision    : 1.0 - initial release
// ============================================================================
module top
  import top_pkg::*;
#(
  parameter int          CLK_HZ     = 12_500_000,
  parameter int          GEN_CYCLES = 6_250_000,
  parameter logic [23:0] ON_GRB     = 24'h100000
) (
  input  logic clk,
  input  logic reset,
  output logic _48b
);

  // A GEN_CYCLES of 0 falls back to a half-second period derived from CLK_HZ
  localparam int GEN_TERM = (GEN_CYCLES > 0) ? GEN_CYCLES : (CLK_HZ / 2);
  localparam int GW       = $clog2(GEN_TERM + 1);

  tx_state_t      state, state_n;
  logic [9:0]     gap_cnt;
  logic [5:0]     led_idx;
  logic [5:0]     tx_led;
  logic [63:0]    board, next_board;
  logic [GW-1:0]  gen_cnt;
  logic           gen_tc, pending, commit;
  logic           start, led_done;
  logic [23:0]    tx_grb;

  // Next generation for every cell, neighbours wrapping around both edges
  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      localparam int RU = (r + 7) % 8;
      localparam int RD = (r + 1) % 8;
      localparam int CL = (c + 7) % 8;
      localparam int CR = (c + 1) % 8;
      logic [3:0] n;
      assign n = 4'(board[RU*8+CL]) + 4'(board[RU*8+c]) + 4'(board[RU*8+CR])
               + 4'(board[r*8+CL])                       + 4'(board[r*8+CR])
               + 4'(board[RD*8+CL]) + 4'(board[RD*8+c]) + 4'(board[RD*8+CR]);
      assign next_board[r*8+c] = life_rule(board[r*8+c], n);
    end
  end

  // LED sampled at its first bit: LED 0 when leaving LATCH, else the next one
  assign tx_led = (state == LATCH) ? 6'd0 : (led_idx + 6'd1);
  assign tx_grb = board[tx_led] ? ON_GRB : 24'h000000;

  // Hold the step off the gap's last cycle, where LED 0 is being sampled
  assign gen_tc = (gen_cnt == GW'(GEN_TERM - 1));
  assign commit = pending && (state == LATCH) && (gap_cnt != 10'(LATCH_CYCLES - 1));

  // Frame sequencer: next state and LED start strobe
  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      LATCH: begin
        if (gap_cnt == 10'(LATCH_CYCLES - 1)) begin
          start   = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (led_done) begin
          if (led_idx == 6'(N_LEDS - 1)) state_n = LATCH;
          else                           start   = 1'b1;
        end
      end
      default: state_n = LATCH;
    endcase
  end

  // Sequencer registers: state, latch-gap counter and LED index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= LATCH;
      gap_cnt <= 10'd0;
      led_idx <= 6'd0;
    end else begin
      state <= state_n;
      if (state == LATCH && state_n == LATCH) gap_cnt <= gap_cnt + 10'd1;
      else                                    gap_cnt <= 10'd0;
      if (state == SEND && led_done)          led_idx <= led_idx + 6'd1;
    end
  end

  // Free-running generation timer, pending-step flag and the board itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_cnt <= '0;
      pending <= 1'b0;
      board   <= SEED_BOARD;
    end else begin
      gen_cnt <= gen_tc ? '0 : (gen_cnt + GW'(1));
      pending <= gen_tc || (pending && !commit);
      if (commit) board <= next_board;
    end
  end

  ws2812_tx u_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .grb      (tx_grb),
    .dout     (_48b),
    .led_done (led_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_top
// Description : Directed self-checking bench for the Game-of-Life display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top;

  localparam logic [23:0] ON      = 24'h100000;
  localparam logic [63:0] SEED    = 64'h0000_0000_0007_0402;
  localparam logic [63:0] GEN1    = 64'h0000_0000_0206_0500;
  localparam logic [63:0] BLINK_V = 64'h0100_0000_0000_0101;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0083;

  logic        clk = 1'b0;
  logic        reset;
  logic        dout;
  int          tests = 0;
  int          fails = 0;
  logic [23:0] grb_cap [64];
  int          hi_w [64][24];
  logic [63:0] live;
  int          bad;
  int          low_cnt;
  time         t_prev;

  top #(.GEN_CYCLES(30000)) dut (
    .clk   (clk),
    .reset (reset),
    ._48b  (dout)
  );

  always #40 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count low cycles (sampled on negedges) until the line goes high, bounded
  task automatic wait_rise(output int n);
    n = 0;
    while (dout !== 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Decode n_leds LEDs starting at the current negedge (first frame cycle)
  task automatic capture(input int n_leds);
    logic [23:0] g;
    int          hi;
    bit          seen_low;
    live = '0;
    bad  = 0;
    for (int l = 0; l < n_leds; l++) begin
      g = '0;
      for (int b = 0; b < 24; b++) begin
        hi       = 0;
        seen_low = 1'b0;
        for (int p = 0; p < 15; p++) begin
          if (dout === 1'b1) begin
            hi++;
            if (seen_low) bad++;
          end else begin
            seen_low = 1'b1;
          end
          @(negedge clk);
        end
        hi_w[l][b] = hi;
        if (hi != 5 && hi != 10) bad++;
        g = {g[22:0], (hi == 10)};
      end
      grb_cap[l] = g;
      if (g == ON)         live[l] = 1'b1;
      else if (g != 24'd0) bad++;
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dout", 64'(dout), 64'd0);
    reset = 1'b0;
    wait_rise(low_cnt);
    chk("reset_gap", 64'(low_cnt), 64'd1000);

    // First frame after reset: timing of LEDs 0 and 1, stop at LED 30
    capture(30);
    chk("led0_grb", 64'(grb_cap[0]), 64'd0);
    chk("led1_grb", 64'(grb_cap[1]), 64'(ON));
    chk("led0_bit0_high", 64'(hi_w[0][0]), 64'd5);
    chk("led1_pulse4_high", 64'(hi_w[1][3]), 64'd10);
    chk("led1_pulse5_high", 64'(hi_w[1][4]), 64'd5);
    chk("partial_shape", 64'(bad), 64'd0);

    // Reset in the middle of LED 30's first bit
    @(negedge clk);
    chk("pre_reset_high", 64'(dout), 64'd1);
    #5 reset = 1'b1;
    #1 chk("midframe_reset_low", 64'(dout), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_rise(low_cnt);
    chk("reset2_gap", 64'(low_cnt), 64'd1000);
    t_prev = $time;

    capture(64);
    chk("frame1_board", live, SEED);
    chk("frame1_shape", 64'(bad), 64'd0);
    wait_rise(low_cnt);
    chk("gap1", 64'(low_cnt), 64'd1000);
    chk("frame_period", 64'(($time - t_prev) / 80), 64'd24040);

    capture(64);
    chk("frame2_board", live, SEED);
    wait_rise(low_cnt);
    chk("gap2", 64'(low_cnt), 64'd1000);

    // Step pending since cycle 30000 is committed in the gap before this frame
    capture(64);
    chk("frame3_board", live, GEN1);
    chk("frame3_shape", 64'(bad), 64'd0);

    // Vertical blinker across the row wrap turns horizontal across the column wrap
    force dut.board = BLINK_V;
    #1 chk("wrap_next", dut.next_board, BLINK_H);
    release dut.board;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
